// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths
// and the UART command FSM state encoding.
package alu_pkg;

  localparam int ALU_NB_DATA = 8;
  localparam int ALU_NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

endpackage

// File: rtl/alu_uart_interface_counter.sv
// Inter-byte idle counter; o_expired flags the edge on which the count reaches TIMEOUT.
// Ports: i_clk, i_reset (sync, high), i_clear, i_enable, o_expired.
module byte_timeout_counter #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at TIMEOUT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the cycle whose closing edge brings the count to TIMEOUT;
  // a clear (accepted byte) in that cycle suppresses it.
  assign o_expired = i_enable & ~i_clear & (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes from UART RX, drives registered ALU inputs,
// captures the result and requests a TX. Ports: i_clk, i_reset, i_rx_*, i_tx_done,
// i_alu_result in; o_alu_a/b/op, o_tx_data, o_tx_start, o_timeout, o_overrun out.
import alu_pkg::*;

module alu_uart_interface #(
  parameter int NB_DATA = ALU_NB_DATA,
  parameter int NB_OP   = ALU_NB_OP,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_timeout,
  output logic               o_overrun
);

  state_e state_q, state_d;

  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic cnt_en;
  logic cnt_clr;
  logic expired;

  // Only the inter-byte waits are timed; everything else holds the counter at 0.
  assign cnt_en  = (state_q == ST_WAIT_B) | (state_q == ST_WAIT_OP);
  assign cnt_clr = i_rx_done | ~cnt_en;

  byte_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (cnt_clr),
    .i_enable  (cnt_en),
    .o_expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        overrun_d  = i_rx_done;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        overrun_d = i_rx_done;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural ALU
// attached; TIMEOUT is shortened to 16 cycles.
`timescale 1ns/1ps
module tb_alu_uart_interface;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_res;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, tmo, ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NB_DATA (8),
    .NB_OP   (6),
    .TIMEOUT (16)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_res),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_timeout    (tmo),
    .o_overrun    (ovr)
  );

  // Behavioural ALU standing in for the real instance.
  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      OP_ADD: alu_res = alu_a + alu_b;
      OP_SUB: alu_res = alu_a - alu_b;
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_NOR: alu_res = ~(alu_a | alu_b);
      OP_SRA: alu_res = 8'($signed(alu_a) >>> alu_b);
      OP_SRL: alu_res = alu_a >> alu_b;
      default: alu_res = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp);
    send(a);
    send(b);
    send(op);
    chk({tag, "_op"}, 32'(alu_op), 32'(op & 8'h3f));
    chk({tag, "_exec_nostart"}, 32'(tx_start), 32'd0);
    tick();
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
    chk({tag, "_start_off"}, 32'(tx_start), 32'd0);
  endtask

  initial begin
    int npulse;
    int at;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a", 32'(alu_a), 32'd0);
    chk("rst_b", 32'(alu_b), 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    run_cmd("add", 8'h05, 8'h03, 8'h20, 8'h08);
    run_cmd("sub", 8'h03, 8'h05, 8'h22, 8'hfe);
    run_cmd("sra", 8'h80, 8'h01, 8'h03, 8'hc0);
    run_cmd("srl", 8'h80, 8'h01, 8'h02, 8'h40);
    run_cmd("opmask", 8'h05, 8'h03, 8'he0, 8'h08);
    run_cmd("bad_op", 8'h05, 8'h03, 8'h3f, 8'h00);

    // Timeout in WAIT_OP: 16 idle cycles, pulse seen on the 16th tick.
    send(8'h05);
    send(8'h03);
    npulse = 0;
    at = -1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (tmo) begin
        npulse++;
        if (at < 0) at = i;
      end
    end
    chk("tmo_pulses", 32'(npulse), 32'd1);
    chk("tmo_cycle", 32'(at), 32'd16);
    chk("tmo_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("tmo_a_hold", 32'(alu_a), 32'h05);
    chk("tmo_b_hold", 32'(alu_b), 32'h03);
    run_cmd("after_tmo", 8'h01, 8'h01, 8'h20, 8'h02);

    // Byte arrives in the very cycle the counter would expire.
    send(8'h07);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("race_pre_tmo", 32'(tmo), 32'd0);
    send(8'h02);
    chk("race_state", 32'(dut.state_q), 32'(ST_WAIT_OP));
    chk("race_b", 32'(alu_b), 32'h02);
    chk("race_no_tmo", 32'(tmo), 32'd0);
    tick();
    chk("race_no_tmo2", 32'(tmo), 32'd0);
    send(8'h20);
    tick();
    chk("race_start", 32'(tx_start), 32'd1);
    chk("race_data", 32'(tx_data), 32'h09);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Overrun during WAIT_TX.
    send(8'h05);
    send(8'h03);
    send(8'h20);
    tick();
    chk("ovr_start", 32'(tx_start), 32'd1);
    send(8'h55);
    chk("ovr_pulse", 32'(ovr), 32'd1);
    chk("ovr_state", 32'(dut.state_q), 32'(ST_WAIT_TX));
    chk("ovr_a_hold", 32'(alu_a), 32'h05);
    chk("ovr_txd_hold", 32'(tx_data), 32'h08);
    tick();
    chk("ovr_once", 32'(ovr), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("ovr_idle", 32'(dut.state_q), 32'(ST_IDLE));
    run_cmd("after_ovr", 8'h02, 8'h03, 8'h20, 8'h05);

    // Stray tx_done in IDLE is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray_txdone", 32'(dut.state_q), 32'(ST_IDLE));

    // Reset in the middle of a command.
    send(8'h07);
    send(8'h09);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_a", 32'(alu_a), 32'd0);
    chk("mrst_b", 32'(alu_b), 32'd0);
    chk("mrst_op", 32'(alu_op), 32'd0);
    chk("mrst_txd", 32'(tx_data), 32'd0);
    chk("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    run_cmd("after_rst", 8'h02, 8'h02, 8'h20, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequential front/back end for the ALU: collects a three-byte command (operand A, operand B, opcode) from the UART receiver and drives the ALU inputs from registers. It then captures the combinational ALU result and hands it to the UART transmitter. Sits between the UART RX/TX blocks and the ALU instance in the board-level top.

## Interface
- `NB_DATA`, 8, width of UART bytes, ALU operands and ALU result
- `NB_OP`, 6, ALU opcode width; the lower `NB_OP` bits of the opcode byte are used
- `TIMEOUT`, 50_000_000, idle cycles allowed between command bytes before the command is aborted
- `i_clk` in 1: single system clock, rising edge
- `i_reset` in 1: synchronous, active-high reset
- `i_rx_data` in `NB_DATA`: received byte, valid when `i_rx_done`=1
- `i_rx_done` in 1: one-cycle pulse per received byte
- `i_tx_done` in 1: one-cycle pulse when the transmitter finishes a byte
- `i_alu_result` in `NB_DATA`: ALU output, signed
- `o_alu_a` out `NB_DATA`: registered operand A
- `o_alu_b` out `NB_DATA`: registered operand B
- `o_alu_op` out `NB_OP`: registered opcode
- `o_tx_data` out `NB_DATA`: result byte to transmit
- `o_tx_start` out 1: one-cycle transmit request
- `o_timeout` out 1: one-cycle pulse, command aborted
- `o_overrun` out 1: one-cycle pulse, byte dropped while busy

## Operation
- FSM states: `IDLE` (awaiting A) → `WAIT_B` → `WAIT_OP` → `EXEC` → `WAIT_TX` → `IDLE`.
- `IDLE`, `i_rx_done`: `o_alu_a` <= `i_rx_data`, go to `WAIT_B`.
- `WAIT_B`, `i_rx_done`: `o_alu_b` <= `i_rx_data`, go to `WAIT_OP`.
- `WAIT_OP`, `i_rx_done`: `o_alu_op` <= `i_rx_data[NB_OP-1:0]`; upper bits are ignored; go to `EXEC`.
- `EXEC` lasts exactly one cycle:
  - `o_tx_data` <= `i_alu_result`
  - `o_tx_start` <= 1
  - go to `WAIT_TX`
- `WAIT_TX`: `i_tx_done` → `IDLE`.
- Invalid opcodes pass through unchanged. The ALU returns 0, and 0x00 is transmitted.
- Operand and opcode registers hold their values until overwritten by the next command.
- Timeout counter:
  - Cleared on every accepted byte and whenever the FSM is in `IDLE`, `EXEC` or `WAIT_TX`.
  - Increments each cycle in `WAIT_B` and `WAIT_OP`.
  - When it reaches `TIMEOUT`, on that edge: go to `IDLE`, pulse `o_timeout`, leave the partially loaded registers unchanged.
- `i_rx_done` while in `EXEC` or `WAIT_TX`: the byte is dropped and `o_overrun` pulses in the next cycle. No state or register changes.
- `i_tx_done` outside `WAIT_TX` is ignored.
- Reset values:
  - state `IDLE`
  - `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data` = 0
  - `o_tx_start`, `o_timeout`, `o_overrun` = 0
  - timeout counter = 0

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Opcode byte strobed in cycle k:
  - `o_alu_op` is valid in cycle k+1 (`EXEC`).
  - The result is latched at the end of k+1.
  - `o_tx_data` is valid and `o_tx_start`=1 in cycle k+2 only.
- Fixed latency: 2 cycles from the opcode `i_rx_done` to `o_tx_start`.
- `o_tx_data` is stable from k+2 until the next `EXEC`.
- Simultaneous events:
  - `i_rx_done` on the cycle the counter hits `TIMEOUT`: the byte wins, it is accepted, and there is no timeout.
  - `i_tx_done` coincident with `o_tx_start`: accepted, go to `IDLE`.
- `i_reset` asserted in any state: next cycle all reset values apply and any partial command is discarded. A pending transmit request is not re-issued.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It saturates and does not wrap.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU opcode localparams: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010
  - `NB_OP` and `NB_DATA` defaults
  - the FSM state encoding (3-bit, five states)
- One sub-module: `byte_timeout_counter`, parameterised by `TIMEOUT`, with ports `i_clk`, `i_reset`, `i_clear`, `i_enable`, `o_expired`.
- The FSM and the data registers stay in `alu_uart_interface`.

## Test plan
- Bytes 0x05, 0x03, 0x20 with `TIMEOUT`=16, ALU connected → `o_tx_start` 2 cycles after the third strobe, `o_tx_data`=0x08. Pulse `i_tx_done` → FSM in `IDLE`.
- Bytes 0x03, 0x05, 0x22 (SUB) → 0xFE. Bytes 0x80, 0x01, 0x03 (SRA) → 0xC0. Bytes 0x80, 0x01, 0x02 (SRL) → 0x40. Opcode byte 0xE0 → lower bits 0x20 → ADD result.
- Bytes 0x05, 0x03, then no byte for 16 cycles → `o_timeout` pulses once, FSM in `IDLE`. Then bytes 0x01, 0x01, 0x20 → 0x02.
- Byte strobe in the cycle the counter expires → accepted, no `o_timeout`.
- Extra `i_rx_done` (0x55) during `WAIT_TX` → `o_overrun` pulses once. The next command is unaffected.
- `i_reset` after bytes A and B → all outputs 0, state `IDLE`. Bytes 0x02, 0x02, 0x20 → 0x04.
